// File: rtl/memory_responder_pkg.sv
// Shared definitions for the memory responder slice.
//   - FSM state and operation encodings
//   - default geometry (DEPTH, ADDR_WIDTH) and wait-state count
//   - data path width and wait counter width
package memory_responder_pkg;

    localparam int unsigned DATA_WIDTH      = 32;
    localparam int unsigned DEF_DEPTH       = 512;
    localparam int unsigned DEF_ADDR_WIDTH  = 9;
    localparam int unsigned DEF_WAIT_STATES = 2;
    // Wide enough for the full 0-15 wait-state range.
    localparam int unsigned CNT_WIDTH       = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2
    } state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous RAM, DATA_WIDTH-bit words, no reset.
//   clk_i   : clock
//   en_i    : port enable; with we_i low the read register loads, else write
//   we_i    : write enable (qualified by en_i)
//   addr_i  : word address
//   wdata_i : write data
//   rdata_o : registered read data, holds when not enabled for read
// Contents are left uninitialised so a simulation can preload mem_q
// hierarchically; reset never touches the array.
module mem_array
  import memory_responder_pkg::*;
#(
  parameter int unsigned DEPTH      = DEF_DEPTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  en_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        mem_q[addr_i] <= wdata_i;
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/memory_responder.sv
// Memory responder: captures a read/write request from MAR/MDR, inserts
// WAIT_STATES idle cycles, then performs the array access and pulses MemDone.
//   clk      : clock, rising edge
//   clr      : asynchronous active-high reset
//   Address  : word address (upper bits ignored, wraps modulo DEPTH)
//   DataIn   : write data
//   Read     : read request (wins over Write when both are high)
//   Write    : write request
//   Mdatain  : registered read data, updated only on read completion
//   MemDone  : registered one-cycle completion pulse
//   Busy     : high whenever the FSM is not idle
module memory_responder
    import memory_responder_pkg::*;
#(
    parameter int unsigned WAIT_STATES = DEF_WAIT_STATES,
    parameter int unsigned DEPTH       = DEF_DEPTH,
    parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic [DATA_WIDTH-1:0] Address,
    input  logic [DATA_WIDTH-1:0] DataIn,
    input  logic                  Read,
    input  logic                  Write,
    output logic [DATA_WIDTH-1:0] Mdatain,
    output logic                  MemDone,
    output logic                  Busy
);

    state_t                state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    op_t                   op_q, op_d;
    logic [DATA_WIDTH-1:0] mdata_q, mdata_d;
    logic                  done_q, done_d;

    logic                  ram_en;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_rdata;

    logic unused_addr_hi;
    assign unused_addr_hi = ^Address[DATA_WIDTH-1:ADDR_WIDTH];

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            op_q    <= OP_READ;
            mdata_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            op_q    <= op_d;
            mdata_q <= mdata_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        data_d   = data_q;
        op_d     = op_q;
        mdata_d  = mdata_q;
        done_d   = 1'b0;
        ram_en   = 1'b0;
        ram_we   = 1'b0;
        ram_addr = addr_q;

        case (state_q)
            IDLE: begin
                // The RAM read register is loaded at the capture edge using the
                // live address, so the registered read data is ready by ACCESS
                // regardless of WAIT_STATES (including zero).
                ram_addr = Address[ADDR_WIDTH-1:0];
                ram_en   = Read;
                if (Read || Write) begin
                    addr_d = Address[ADDR_WIDTH-1:0];
                    data_d = DataIn;
                    op_d   = Read ? OP_READ : OP_WRITE;
                    if (WAIT_STATES == 0) begin
                        state_d = ACCESS;
                        cnt_d   = '0;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_WIDTH'(WAIT_STATES);
                    end
                end
            end
            WAIT: begin
                cnt_d = (cnt_q != '0) ? cnt_q - CNT_WIDTH'(1) : '0;
                if (cnt_q <= CNT_WIDTH'(1)) begin
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                state_d = IDLE;
                done_d  = 1'b1;
                if (op_q == OP_WRITE) begin
                    ram_en = 1'b1;
                    ram_we = 1'b1;
                end else begin
                    mdata_d = ram_rdata;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    mem_array #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk_i   (clk),
        .en_i    (ram_en),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (data_q),
        .rdata_o (ram_rdata)
    );

    assign Mdatain = mdata_q;
    assign MemDone = done_q;
    assign Busy    = (state_q != IDLE);

endmodule

// File: tb/tb_memory_responder.sv
module tb_memory_responder;

    localparam int WS_A = 2;

    logic        clk;
    logic        clr;

    logic [31:0] addr_a, din_a, mdata_a;
    logic        rd_a, wr_a, done_a, busy_a;

    logic [31:0] addr_z, din_z, mdata_z;
    logic        rd_z, wr_z, done_z, busy_z;

    memory_responder #(
        .WAIT_STATES (WS_A),
        .DEPTH       (512),
        .ADDR_WIDTH  (9)
    ) dut (
        .clk     (clk),
        .clr     (clr),
        .Address (addr_a),
        .DataIn  (din_a),
        .Read    (rd_a),
        .Write   (wr_a),
        .Mdatain (mdata_a),
        .MemDone (done_a),
        .Busy    (busy_a)
    );

    memory_responder #(
        .WAIT_STATES (0),
        .DEPTH       (512),
        .ADDR_WIDTH  (9)
    ) dut0 (
        .clk     (clk),
        .clr     (clr),
        .Address (addr_z),
        .DataIn  (din_z),
        .Read    (rd_z),
        .Write   (wr_z),
        .Mdatain (mdata_z),
        .MemDone (done_z),
        .Busy    (busy_z)
    );

    typedef struct {
        bit          rd;
        logic [8:0]  addr;
        logic [31:0] data;
        int          issue;
    } txn_t;

    txn_t        sbq[$];
    txn_t        mon_e;
    logic [31:0] model [512];
    logic [31:0] exp_mdata;
    int          cyc;
    int          done_cnt;
    int          n_checks;
    int          n_errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Scoreboard monitor for the WAIT_STATES=2 instance.
    always @(posedge clk) begin
        #1;
        if (!clr && done_a) begin
            done_cnt++;
            if (sbq.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                mon_e = sbq.pop_front();
                check("latency", 32'(cyc - mon_e.issue), 32'(WS_A + 1));
                if (mon_e.rd) begin
                    exp_mdata = model[mon_e.addr];
                    check("read_data", mdata_a, exp_mdata);
                end else begin
                    model[mon_e.addr] = mon_e.data;
                    check("mdata_hold", mdata_a, exp_mdata);
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge after the capture edge.
    task automatic do_req(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
        txn_t t;
        rd_a   = r;
        wr_a   = w;
        addr_a = a;
        din_a  = d;
        @(posedge clk);
        #1;
        t.rd    = r;
        t.addr  = a[8:0];
        t.data  = d;
        t.issue = cyc;
        sbq.push_back(t);
        @(negedge clk);
        rd_a = 1'b0;
        wr_a = 1'b0;
        check("busy_in_wait", {31'd0, busy_a}, 32'd1);
    endtask

    task automatic wait_done();
        int start;
        start = done_cnt;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done_cnt != start) return;
        end
        check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        int saved;
        n_checks  = 0;
        n_errors  = 0;
        done_cnt  = 0;
        cyc       = 0;
        exp_mdata = '0;
        clr = 1'b1;
        {rd_a, wr_a, addr_a, din_a} = '0;
        {rd_z, wr_z, addr_z, din_z} = '0;

        idle(3);
        check("rst_busy",  {31'd0, busy_a}, 32'd0);
        check("rst_done",  {31'd0, done_a}, 32'd0);
        check("rst_mdata", mdata_a, 32'd0);
        check("rst0_busy", {31'd0, busy_z}, 32'd0);
        check("rst0_mdata", mdata_z, 32'd0);
        clr = 1'b0;
        idle(2);

        // Write then back-to-back read of the same word.
        do_req(0, 1, 32'h10, 32'hDEADBEEF);
        wait_done();
        do_req(1, 0, 32'h10, 32'h0);
        wait_done();

        // Address wrap modulo DEPTH.
        do_req(0, 1, 32'h205, 32'h12345678);
        wait_done();
        do_req(1, 0, 32'h005, 32'h0);
        wait_done();

        // Simultaneous Read and Write behaves as a read.
        do_req(0, 1, 32'h20, 32'hA5A5A5A5);
        wait_done();
        do_req(1, 1, 32'h20, 32'h0);
        wait_done();
        do_req(1, 0, 32'h20, 32'h0);
        wait_done();

        // Reset during WAIT of a write aborts it.
        do_req(0, 1, 32'h30, 32'h1);
        wait_done();
        saved = done_cnt;
        do_req(0, 1, 32'h30, 32'hFFFFFFFF);
        clr = 1'b1;
        #1;
        check("abort_busy",  {31'd0, busy_a}, 32'd0);
        check("abort_mdata", mdata_a, 32'd0);
        check("abort_done",  {31'd0, done_a}, 32'd0);
        void'(sbq.pop_back());
        exp_mdata = '0;
        @(negedge clk);
        clr = 1'b0;
        idle(6);
        check("abort_no_done", 32'(done_cnt - saved), 32'd0);
        do_req(1, 0, 32'h30, 32'h0);
        wait_done();

        // Inputs ignored while busy.
        do_req(0, 1, 32'h40, 32'h40404040);
        wait_done();
        saved = done_cnt;
        rd_a   = 1'b1;
        addr_a = 32'h40;
        @(posedge clk);
        #1;
        sbq.push_back('{rd: 1'b1, addr: 9'h40, data: 32'h0, issue: cyc});
        @(negedge clk);
        rd_a   = 1'b0;
        wr_a   = 1'b1;
        din_a  = 32'hBAD0BAD0;
        @(negedge clk);
        addr_a = 32'h41;
        @(negedge clk);
        wr_a   = 1'b0;
        addr_a = '0;
        wait_done();
        idle(6);
        check("ignore_one_done", 32'(done_cnt - saved), 32'd1);
        do_req(1, 0, 32'h40, 32'h0);
        wait_done();
        check("sb_empty", 32'(sbq.size()), 32'd0);

        // WAIT_STATES=0 instance: write, then Read held for three reads.
        wr_z   = 1'b1;
        addr_z = 32'h7;
        din_z  = 32'h0BADCAFE;
        @(posedge clk);
        #1;
        check("z_wr_busy", {31'd0, busy_z}, 32'd1);
        @(negedge clk);
        wr_z = 1'b0;
        @(posedge clk);
        #1;
        check("z_wr_done", {31'd0, done_z}, 32'd1);
        @(negedge clk);
        saved = 0;
        rd_z  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check("z_b2b_busy", {31'd0, busy_z}, (i % 2 == 0) ? 32'd1 : 32'd0);
            check("z_b2b_done", {31'd0, done_z}, (i % 2 == 1) ? 32'd1 : 32'd0);
            if (done_z) saved++;
        end
        @(negedge clk);
        rd_z = 1'b0;
        @(posedge clk);
        #1;
        check("z_end_done", {31'd0, done_z}, 32'd0);
        check("z_end_busy", {31'd0, busy_z}, 32'd0);
        check("z_done_count", 32'(saved), 32'd3);
        check("z_mdata", mdata_z, 32'h0BADCAFE);

        idle(2);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
